// File: rtl/grayscale_sched.sv
// rtl/grayscale_sched.sv - grayscale job sequencer: credit-limited line reads, pipeline-driven writes, ack counting
module grayscale_sched #(
    parameter int ADDR_W          = 42,
    parameter int LEN_W           = 32,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  num_lines,
    input  logic              c0_almfull,
    input  logic              c1_almfull,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              pipe_valid,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    input  logic              wr_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [LEN_W-1:0]  lines_written
);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  src_q;
    logic [ADDR_W-1:0]  dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rd_cnt;
    logic [LEN_W-1:0]   wr_cnt;
    logic [LEN_W-1:0]   ack_cnt;
    logic [LEN_W-1:0]   inflight;

    logic active;
    logic issue;
    logic wr_fire;

    assign active  = (state == ST_READ) || (state == ST_DRAIN);
    // inflight covers lines read but not yet written, i.e. the pipeline's occupancy
    assign issue   = (state == ST_READ) && !c0_almfull && !c1_almfull &&
                     (inflight < LEN_W'(MAX_OUTSTANDING)) && (rd_cnt < len_q);
    assign wr_fire = active && pipe_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            ack_cnt       <= '0;
            inflight      <= '0;
            rd_req_valid  <= 1'b0;
            rd_req_addr   <= '0;
            wr_req_valid  <= 1'b0;
            wr_req_addr   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_overflow  <= 1'b0;
            lines_written <= '0;
        end else begin
            rd_req_valid <= 1'b0;
            wr_req_valid <= 1'b0;
            done         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_q         <= src_base;
                        dst_q         <= dst_base;
                        len_q         <= num_lines;
                        rd_cnt        <= '0;
                        wr_cnt        <= '0;
                        ack_cnt       <= '0;
                        inflight      <= '0;
                        lines_written <= '0;
                        err_overflow  <= 1'b0;
                        if (num_lines == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_req_valid <= 1'b1;
                        rd_req_addr  <= src_q + ADDR_W'(rd_cnt);
                        rd_cnt       <= rd_cnt + LEN_W'(1);
                        if (rd_cnt + LEN_W'(1) == len_q) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ack_cnt == len_q) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // The pipeline cannot be stalled, so writes go out even when they are illegal
            if (wr_fire) begin
                wr_req_valid <= 1'b1;
                wr_req_addr  <= dst_q + ADDR_W'(wr_cnt);
                wr_cnt       <= wr_cnt + LEN_W'(1);
                if (c1_almfull) begin
                    err_overflow <= 1'b1;
                end
            end else if (pipe_valid) begin
                err_overflow <= 1'b1;
            end

            if (issue && !wr_fire) begin
                inflight <= inflight + LEN_W'(1);
            end else if (!issue && wr_fire) begin
                if (inflight == '0) begin
                    err_overflow <= 1'b1;
                end else begin
                    inflight <= inflight - LEN_W'(1);
                end
            end

            if (wr_rsp_valid) begin
                if (active && (ack_cnt != len_q)) begin
                    ack_cnt       <= ack_cnt + LEN_W'(1);
                    lines_written <= ack_cnt + LEN_W'(1);
                end else begin
                    err_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_grayscale_sched.sv
// tb/tb_grayscale_sched.sv - scoreboard bench for grayscale_sched with a modelled pipeline and ack path
module tb_grayscale_sched;
    localparam int AW = 42;
    localparam int LW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [LW-1:0] num_lines = '0;
    logic          c0_almfull = 1'b0;
    logic          c1_almfull = 1'b0;
    logic          pipe_auto = 1'b0;
    logic          manual_pipe = 1'b0;
    logic          wr_rsp_valid = 1'b0;
    logic          pipe_valid;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic          wr_req_valid;
    logic [AW-1:0] wr_req_addr;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic [LW-1:0] lines_written;

    assign pipe_valid = pipe_auto | manual_pipe;

    grayscale_sched #(.ADDR_W(AW), .LEN_W(LW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .num_lines(num_lines),
        .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .pipe_valid(pipe_valid),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
        .wr_rsp_valid(wr_rsp_valid),
        .busy(busy), .done(done), .err_overflow(err_overflow),
        .lines_written(lines_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] exp_wr[$];
    int ahead = 0;
    int max_ahead = 0;
    bit auto_pipe = 1'b1;
    int pipe_delay = 5;
    int cyc = 0;
    int pipe_q[$];
    int ack_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Pipeline echoes each read after pipe_delay cycles; memory acks each write 3 cycles later
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            pipe_q.delete();
            ack_q.delete();
            pipe_auto    = 1'b0;
            wr_rsp_valid = 1'b0;
        end else begin
            if (rd_req_valid && auto_pipe) pipe_q.push_back(cyc + pipe_delay);
            if (wr_req_valid) ack_q.push_back(cyc + 3);
            pipe_auto = 1'b0;
            if (pipe_q.size() > 0 && pipe_q[0] == cyc) begin
                pipe_auto = 1'b1;
                void'(pipe_q.pop_front());
            end
            wr_rsp_valid = 1'b0;
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                wr_rsp_valid = 1'b1;
                void'(ack_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_req_valid) begin
                ahead++;
                if (ahead > max_ahead) max_ahead = ahead;
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=0x%0h expected=none", rd_req_addr);
                end else begin
                    chk("rd_addr", rd_req_addr, exp_rd.pop_front());
                end
            end
            if (wr_req_valid) begin
                ahead--;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=0x%0h expected=none", wr_req_addr);
                end else begin
                    chk("wr_addr", wr_req_addr, exp_wr.pop_front());
                end
            end
        end
    end

    task automatic start_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(s + AW'(i));
            exp_wr.push_back(d + AW'(i));
        end
        src_base  = s;
        dst_base  = d;
        num_lines = LW'(n);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        int extra = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        repeat (5) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({name, "_done_once"}, 64'(extra), 64'd0);
    endtask

    task automatic wait_reads(input string name, input int k, input int budget);
        int got = 0;
        for (int i = 0; i < budget && got < k; i++) begin
            @(negedge clk);
            if (rd_req_valid) got++;
        end
        chk({name, "_reads_seen"}, 64'(got), 64'(k));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", 64'(rd_req_valid), 64'd0);
        chk("rst_wr_valid", 64'(wr_req_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        chk("rst_lines", 64'(lines_written), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic job: four back-to-back reads, first one two cycles after start
        start_job(42'h100, 42'h200, 4);
        chk("t1_rd_latency", 64'(rd_req_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_back_to_back", 64'(rd_req_valid), 64'd1);
        end
        wait_done("t1", 200);
        chk("t1_lines", 64'(lines_written), 64'd4);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_err", 64'(err_overflow), 64'd0);
        chk("t1_rd_left", 64'(exp_rd.size()), 64'd0);
        chk("t1_wr_left", 64'(exp_wr.size()), 64'd0);

        // Zero-length job
        start_job(42'h0, 42'h0, 0);
        chk("t2_done_early", 64'(done), 64'd0);
        chk("t2_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t2_done_pulse", 64'(done), 64'd1);
        chk("t2_busy1", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t2_done_gone", 64'(done), 64'd0);
        chk("t2_lines", 64'(lines_written), 64'd0);

        // Credit limit against a slow pipeline
        max_ahead  = 0;
        pipe_delay = 20;
        start_job(42'h1000, 42'h2000, 8);
        wait_done("t3", 600);
        chk("t3_max_ahead", 64'(max_ahead), 64'(MO));
        chk("t3_lines", 64'(lines_written), 64'd8);
        chk("t3_wr_left", 64'(exp_wr.size()), 64'd0);

        // Read channel almost-full mid-job
        pipe_delay = 5;
        start_job(42'h300, 42'h400, 16);
        wait_reads("t4", 3, 50);
        c0_almfull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_stall", 64'(rd_req_valid), 64'd0);
        end
        c0_almfull = 1'b0;
        wait_done("t4", 800);
        chk("t4_lines", 64'(lines_written), 64'd16);
        chk("t4_rd_left", 64'(exp_rd.size()), 64'd0);
        chk("t4_err", 64'(err_overflow), 64'd0);

        // Pipeline beat while the write channel is almost full
        auto_pipe = 1'b0;
        start_job(42'h50, 42'h60, 1);
        wait_reads("t5", 1, 20);
        c1_almfull  = 1'b1;
        manual_pipe = 1'b1;
        @(negedge clk);
        c1_almfull  = 1'b0;
        manual_pipe = 1'b0;
        chk("t5_wr_issued", 64'(wr_req_valid), 64'd1);
        chk("t5_err_set", 64'(err_overflow), 64'd1);
        wait_done("t5", 100);
        chk("t5_err_sticky", 64'(err_overflow), 64'd1);
        chk("t5_lines", 64'(lines_written), 64'd1);
        auto_pipe = 1'b1;

        // Reset in the middle of a read phase, then a fresh job
        start_job(42'h500, 42'h600, 16);
        chk("t6_err_cleared", 64'(err_overflow), 64'd0);
        wait_reads("t6", 3, 50);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rd", 64'(rd_req_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_lines", 64'(lines_written), 64'd0);
        exp_rd.delete();
        exp_wr.delete();
        repeat (3) @(negedge clk);
        chk("t6_rst_done", 64'(done), 64'd0);
        exp_rd.delete();
        exp_wr.delete();
        reset_n = 1'b1;
        @(negedge clk);
        start_job(42'h700, 42'h800, 2);
        wait_done("t6", 200);
        chk("t6_lines", 64'(lines_written), 64'd2);
        chk("t6_err", 64'(err_overflow), 64'd0);
        chk("t6_rd_left", 64'(exp_rd.size()), 64'd0);
        chk("t6_wr_left", 64'(exp_wr.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
